// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI memory arbiter.
// Holds the default address/data/wait-counter widths and the host FSM
// state encoding used by spi_mem_arbiter.
package spi_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int WAIT_W_DEF = 4;

    typedef enum logic [0:0] {
        HOST_IDLE = 1'b0,
        HOST_ACK  = 1'b1
    } host_state_e;

endpackage

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one external single-port synchronous memory
// between an SPI slave (absolute priority, single-cycle request pulses) and
// a host (level request held until host_ack, two-state IDLE/ACK handshake).
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   spi_cs/req/we/addr/wdata  SPI access request (qualified by spi_cs low)
//   spi_rvalid/rdata      SPI read response, one cycle after the issue
//   host_req/we/addr/wdata    host access request
//   host_ack/rdata        host completion pulse and read data
//   host_wait_cnt         saturating count of cycles the host request waited
//   mem_en/we/addr/wdata  memory strobe and command (zero when idle)
//   mem_rdata             memory read data, one cycle after a read strobe
//
// The SPI issue path is combinational (issued on mem_* in the request cycle);
// the address lock keeps the host from overwriting a word the SPI master is
// still working with during the current chip-select window.
module spi_mem_arbiter
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_rvalid,
    output logic [DATA_W-1:0] spi_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [WAIT_W-1:0] host_wait_cnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    host_state_e       state_r;
    host_state_e       state_nx_s;
    logic              spi_issue_s;
    logic              host_blocked_s;
    logic              host_issue_s;
    logic              lock_valid_r;
    logic [ADDR_W-1:0] lock_addr_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              spi_rd_pend_r;
    logic              host_rd_r;

    // Saturating increment for the host wait counter.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v == {WAIT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Request qualification; reset gating keeps mem_* quiet while reset is high.
    always_comb begin
        spi_issue_s    = ~reset & spi_req & ~spi_cs;
        host_blocked_s = lock_valid_r & host_we & (host_addr == lock_addr_r);
    end

    // Host FSM next state and host issue decision.
    always_comb begin
        state_nx_s   = state_r;
        host_issue_s = 1'b0;
        case (state_r)
            HOST_IDLE: begin
                if (~reset & host_req & ~spi_issue_s & ~host_blocked_s) begin
                    host_issue_s = 1'b1;
                    state_nx_s   = HOST_ACK;
                end else begin
                    state_nx_s   = HOST_IDLE;
                end
            end
            HOST_ACK: begin
                state_nx_s = HOST_IDLE;
            end
            default: begin
                state_nx_s = HOST_IDLE;
            end
        endcase
    end

    // Host FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= HOST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Address lock: armed by each qualified SPI access, dropped when cs rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_valid_r <= 1'b0;
            lock_addr_r  <= {ADDR_W{1'b0}};
        end else if (spi_cs) begin
            lock_valid_r <= 1'b0;
        end else if (spi_issue_s) begin
            lock_valid_r <= 1'b1;
            lock_addr_r  <= spi_addr;
        end else begin
            lock_valid_r <= lock_valid_r;
        end
    end

    // Host wait counter: counts unserved IDLE cycles, clears on issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (host_issue_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if ((state_r == HOST_IDLE) && host_req) begin
            wait_cnt_r <= sat_inc(wait_cnt_r);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Pending read flags: mark which requester owns next cycle's mem_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_rd_pend_r <= 1'b0;
            host_rd_r     <= 1'b0;
        end else begin
            spi_rd_pend_r <= spi_issue_s & ~spi_we;
            host_rd_r     <= host_issue_s & ~host_we;
        end
    end

    // Memory command mux: SPI first, then host, otherwise all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (spi_issue_s) begin
            mem_en    = 1'b1;
            mem_we    = spi_we;
            mem_addr  = spi_addr;
            mem_wdata = spi_wdata;
        end else if (host_issue_s) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Responses: read data is steered through only alongside its valid flag.
    always_comb begin
        spi_rvalid    = spi_rd_pend_r;
        spi_rdata     = spi_rd_pend_r ? mem_rdata : {DATA_W{1'b0}};
        host_ack      = (state_r == HOST_ACK);
        host_rdata    = host_rd_r ? mem_rdata : {DATA_W{1'b0}};
        host_wait_cnt = wait_cnt_r;
    end

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 7, data memory address width.
REQ-002 Parameter: DATA_W, 8, data memory word width.
REQ-003 Parameter: WAIT_W, 4, width of the host wait counter.
REQ-004 Ports: one clock; reset asynchronous, active-high.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- spi_cs  in  1  SPI chip select level; high = idle, low = transaction active.
- spi_req  in  1  one-cycle access request from the SPI slave.
- spi_we  in  1  SPI write (1) or read (0).
- spi_addr  in  ADDR_W  SPI access address.
- spi_wdata  in  DATA_W  SPI write data.
- spi_rvalid  out  1  SPI read data valid pulse.
- spi_rdata  out  DATA_W  SPI read data.
- host_req  in  1  host request level; held until host_ack.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  ADDR_W  host access address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  host completion pulse; host_rdata valid with it.
- host_rdata  out  DATA_W  host read data.
- host_wait_cnt  out  WAIT_W  cycles the current host request has waited, saturating.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-005 The block SHALL share one single-port synchronous memory between the SPI requester and the host requester, issuing at most one access per cycle.
REQ-006 The SPI requester SHALL have absolute priority: a spi_req with spi_cs low SHALL be issued on mem_* in the same cycle.
REQ-007 A spi_req while spi_cs is high SHALL be ignored: no mem_en, no spi_rvalid, no lock update.
REQ-008 An issued SPI read SHALL produce spi_rvalid=1 with spi_rdata=mem_rdata exactly one cycle later. SPI writes SHALL produce no response.
REQ-009 Host FSM states: IDLE and ACK. In IDLE, the host request SHALL be issued only when:
- host_req=1;
- no qualified spi_req is present that cycle;
- the request is not lock-blocked (REQ-011).
Issuing the host request moves the FSM to ACK.
REQ-010 In ACK, host_ack=1 (host_rdata=mem_rdata for reads), no host access SHALL be issued, and the FSM SHALL return to IDLE next cycle. Sustained throughput is therefore one host access per two cycles.
REQ-011 Address lock:
- Each qualified SPI access SHALL set lock_valid=1 and lock_addr=spi_addr.
- spi_cs high SHALL clear lock_valid on the next edge.
- While lock_valid=1, a host write with host_addr==lock_addr SHALL be held off.
- Host reads SHALL never be lock-blocked.
REQ-012 host_wait_cnt SHALL increment each cycle in which host_req=1 in IDLE and the request is not issued, saturate at 2^WAIT_W-1, and clear to 0 on issue.
REQ-013 Simultaneous spi_req and host_req: the SPI access SHALL be issued, the host request SHALL wait, and host_wait_cnt SHALL increment.
REQ-014 A spi_req arriving while the host FSM is in ACK SHALL be issued normally. Host response and SPI issue SHALL proceed in the same cycle.
REQ-015 mem_we, mem_addr, and mem_wdata SHALL be driven from the granted requester when mem_en=1, and held at 0 when mem_en=0.

Reset
REQ-016 While reset=1, the block SHALL force:
- host FSM=IDLE;
- lock_valid=0, lock_addr=0, host_wait_cnt=0;
- spi_rvalid=0, host_ack=0;
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
- spi_rdata=0, host_rdata=0.
REQ-017 Reset asserted mid-operation SHALL discard any pending read response; no spi_rvalid or host_ack SHALL follow reset release without a new request.

Structure
REQ-018 ADDR_W and DATA_W defaults and the host FSM state encodings SHALL live in the shared spi_pkg package.
REQ-019 The block SHALL be a single module with no sub-modules; the data memory SHALL remain external.

Verification
REQ-020 SPI read: spi_cs=0, spi_req at cycle N, addr 0x12, memory holds 0xA5 -> mem_en=1 at N, spi_rvalid=1 with spi_rdata=0xA5 at N+1.
REQ-021 Collision: spi_req (addr 0x05) and host_req read (addr 0x06) at cycle N -> SPI issued at N, host issued at N+1, host_ack at N+2, host_wait_cnt=1 during N+1.
REQ-022 Lock: SPI access to 0x20 with cs low, then host write 0x20 <- 0x3C -> held off (host_wait_cnt rising) until spi_cs high, then issued with mem_we=1, mem_addr=0x20, mem_wdata=0x3C.
REQ-023 Ignored request: spi_req with spi_cs=1 -> no mem_en, no spi_rvalid; a following host write to the same address is issued immediately.
REQ-024 Saturation and reset: continuous spi_req for 20 cycles with host_req held -> host_wait_cnt saturates at 15. Asserting reset during a pending read -> all outputs 0, no host_ack after release.
